// File: rtl/reset_conditioner.sv
// Merges the board reset sources (KEY[0] switch, Prop-plug DTR) into one clean, stretched active-low reset for p1v.
// Optional RESET_CAUSE_EN adds the last_cause register/port recording which source(s) caused the latest reset.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_ASSERT | a source is active (or just left reset); resn held low
// S_HOLD   | all sources released; counting HOLD_CYCLES before release
// S_RUN    | core running; resn high
module reset_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1600000,
   parameter int PLUG_FILTER     = 8,
   parameter int HOLD_CYCLES     = 16000
) (
   input  logic       clock_160,
   input  logic       reset,
   input  logic       key_n,
   input  logic       plug_resn,
   output logic       resn
`ifdef RESET_CAUSE_EN
   ,
   output logic [1:0] last_cause
`endif
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PF_W = $clog2(PLUG_FILTER + 1);
   localparam int HD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PF_W-1:0] PF_LAST = PF_W'(PLUG_FILTER - 1);
   localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_ASSERT = 2'd0,
      S_HOLD   = 2'd1,
      S_RUN    = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] key_sync;
   logic [SYNC_STAGES-1:0] plug_sync;
   logic                   key_s;
   logic                   plug_s;

   logic [DB_W-1:0]        db_cnt;
   logic                   key_db;
   logic [PF_W-1:0]        pf_cnt;
   logic                   plug_flt;
   logic                   req;

   state_t                 state;
   state_t                 next_state;
   logic [HD_W-1:0]        hold_cnt;
   logic [HD_W-1:0]        hold_next;

   // Synchronisers reset to the inactive level so reset release never looks like a press.
   always_ff @(posedge clock_160) begin
      if (reset) begin
         key_sync  <= '1;
         plug_sync <= '1;
      end else begin
         key_sync  <= {key_sync[SYNC_STAGES-2:0], key_n};
         plug_sync <= {plug_sync[SYNC_STAGES-2:0], plug_resn};
      end
   end

   assign key_s  = key_sync[SYNC_STAGES-1];
   assign plug_s = plug_sync[SYNC_STAGES-1];

   always_ff @(posedge clock_160) begin
      if (reset) begin
         db_cnt <= '0;
         key_db <= 1'b1;
      end else if (key_s == key_db) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         key_db <= key_s;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   // Asymmetric filter: assertion needs PLUG_FILTER low samples, release is immediate.
   always_ff @(posedge clock_160) begin
      if (reset) begin
         pf_cnt   <= '0;
         plug_flt <= 1'b1;
      end else if (plug_s) begin
         pf_cnt   <= '0;
         plug_flt <= 1'b1;
      end else if (pf_cnt == PF_LAST) begin
         plug_flt <= 1'b0;
      end else begin
         pf_cnt <= pf_cnt + PF_W'(1);
      end
   end

   assign req = ~key_db | ~plug_flt;

   always_comb begin
      next_state = state;
      hold_next  = hold_cnt;
      case (state)
         S_ASSERT: begin
            if (!req) begin
               next_state = S_HOLD;
               hold_next  = '0;
            end
         end
         S_HOLD: begin
            if (req) begin
               next_state = S_ASSERT;
               hold_next  = '0;
            end else if (hold_cnt == HD_LAST) begin
               next_state = S_RUN;
            end else begin
               hold_next = hold_cnt + HD_W'(1);
            end
         end
         S_RUN: begin
            if (req) begin
               next_state = S_ASSERT;
            end
         end
         default: begin
            next_state = S_ASSERT;
            hold_next  = '0;
         end
      endcase
   end

   // resn is registered from next_state so it moves on the same edge as the FSM.
   always_ff @(posedge clock_160) begin
      if (reset) begin
         state    <= S_ASSERT;
         hold_cnt <= '0;
         resn     <= 1'b0;
      end else begin
         state    <= next_state;
         hold_cnt <= hold_next;
         resn     <= (next_state == S_RUN);
      end
   end

`ifdef RESET_CAUSE_EN
   logic cause_fresh;

   // cause_fresh marks the first ASSERT edge of an episode, where the record is reloaded.
   always_ff @(posedge clock_160) begin
      if (reset) begin
         last_cause  <= 2'b00;
         cause_fresh <= 1'b1;
      end else begin
         cause_fresh <= (state != S_ASSERT);
         if (state == S_ASSERT) begin
            if (cause_fresh) begin
               last_cause <= {~plug_flt, ~key_db};
            end else begin
               last_cause <= last_cause | {~plug_flt, ~key_db};
            end
         end
      end
   end
`endif

endmodule

// File: doc/reset_conditioner.md
Name: reset_conditioner

Overview:
- Conditions the two asynchronous reset sources on the DE0-Nano board into one clean, glitch-free, minimum-width active-low reset for the p1v core (`inp_resn`).
  - KEY[0] is the tactile switch.
  - GPIO0[25] is the Prop-plug DTR reset.
- Synchronises both sources, debounces the switch and glitch-filters the Prop-plug line.
- Stretches every reset event to at least HOLD_CYCLES after release.
- Sits between the board pins and p1v in the board top level, replacing the current combinational AND of the two sources.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per asynchronous input (min 2).
- DEBOUNCE_CYCLES, 1600000, consecutive stable samples needed before the debounced key changes state (10 ms at 160 MHz).
- PLUG_FILTER, 8, consecutive low samples needed before a Prop-plug reset is accepted; release is accepted on the first high sample.
- HOLD_CYCLES, 16000, minimum cycles resn stays low after all sources are released (100 us at 160 MHz).

Ports:
- clock_160, in, 1, system clock; all logic on the rising edge.
- reset, in, 1, synchronous active-high reset (PLL not locked / power-on).
- key_n, in, 1, KEY[0], asynchronous, active-low.
- plug_resn, in, 1, GPIO0[25], asynchronous, active-low.
- resn, out, 1, registered conditioned reset to p1v `inp_resn`, active-low.
- last_cause, out, 2, present only with RESET_CAUSE_EN; bit0 = key, bit1 = Prop plug.

Behaviour:
- Reset (reset=1 at a rising edge):
  - All synchroniser flops load 1 (inactive).
  - key_db = 1, plug_flt = 1, all counters = 0.
  - State = ASSERT, resn = 0.
  - last_cause = 2'b00.
- Synchronisers: each input passes through SYNC_STAGES flops, giving key_s and plug_s.
- Key debounce:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - The counter clears whenever key_s == key_db.
  - Otherwise it increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and key_s still differs, key_db <= key_s and the counter clears.
  - Debounce is symmetric: press and release use the same count.
- Plug filter:
  - When plug_s=0, the counter increments and saturates at PLUG_FILTER-1.
  - The cycle it is at PLUG_FILTER-1 with plug_s=0, plug_flt <= 0.
  - When plug_s=1, the counter and plug_flt clear/set immediately: counter <= 0, plug_flt <= 1.
  - Low pulses shorter than PLUG_FILTER samples are ignored.
- req = ~key_db | ~plug_flt (combinational).
- FSM, with states ASSERT, HOLD, RUN:
  - ASSERT:
    - req=1: stay.
    - req=0: go to HOLD, hold counter <= 0.
  - HOLD:
    - req=1: go to ASSERT, counter <= 0.
    - Counter == HOLD_CYCLES-1: go to RUN.
    - Otherwise the counter increments.
  - RUN:
    - req=1: go to ASSERT.
- Output: resn <= (next_state == RUN).
  - resn falls on the same edge the FSM enters ASSERT.
  - resn rises on the same edge the FSM enters RUN.
- Latency:
  - RUN to resn=0: one edge after req rises.
  - Release: resn=1 exactly HOLD_CYCLES edges after the edge that enters HOLD.
- Boundary cases:
  - Simultaneous key and plug: the OR is handled naturally; release waits for both.
  - Re-assertion during HOLD restarts the full HOLD interval.
  - reset asserted mid-HOLD or mid-debounce: immediate return to reset values, resn=0 the same edge.
  - After reset deassert with both inputs inactive: ASSERT, then HOLD next edge, then resn=1 after HOLD_CYCLES more edges.
- No combinational path from any input to resn.

Optional Feature:
- Macro: RESET_CAUSE_EN.
- With the macro defined:
  - last_cause is a register, cleared only by `reset`.
  - On each edge where the FSM is in ASSERT, last_cause <= {~plug_flt, ~key_db} on ASSERT entry, then ORs in newly active sources while in ASSERT.
  - It is held unchanged in HOLD and RUN.
  - Intended for routing to spare LEDs for board debugging.
- Without the macro:
  - The last_cause port and its register are absent.
  - All other behaviour is identical.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=8, PLUG_FILTER=4, HOLD_CYCLES=16):
1. reset high for 3 cycles, then low, with key_n=1 and plug_resn=1 -> resn=0 throughout reset, rises exactly 17 edges after reset drops (1 ASSERT→HOLD + 16), and stays 1.
2. In RUN, key_n bounces (low 3, high 2, low 3 cycles), then stays high -> resn stays 1. key_n held low 12 cycles -> resn falls within 2+8+1 edges; after release, resn returns to 1 only after debounce (8) + HOLD (16).
3. In RUN, plug_resn low for 3 cycles -> no reset. Low for 6 cycles -> resn=0 after the filter count; after release, resn=1 exactly 16 edges after HOLD entry.
4. Plug released during HOLD and re-asserted 10 cycles into HOLD for 5 cycles -> FSM returns to ASSERT; resn rises only 16 edges after the second HOLD entry.
5. Key and plug asserted together, plug released first, key released 20 cycles later -> resn stays 0 until key_db releases + 16. With RESET_CAUSE_EN: last_cause=2'b11.
6. reset pulsed for 1 cycle at HOLD count 9 -> resn=0 on that edge; the sequence restarts per scenario 1 and last_cause=2'b00.
